// File: rtl/npu_io_pkg.sv
// Shared definitions for the NPU I/O blocks: state encodings common to the
// serial shifters and a constant-function clog2 for derived widths.
package npu_io_pkg;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    // Smallest r with 2**r >= v; v <= 1 yields 0.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sipo_in_ctrl.sv
// Fill/full controller for sipo_in: word counter, READY/DATA_VALID handshake
// and, when SIPO_IN_OVF_EN is defined, the sticky overflow flag.
module sipo_in_ctrl
    import npu_io_pkg::*;
#(
    parameter int NUM_TAPS = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             ack_i,
    output logic             ready_o,
    output logic             capture_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o
);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign ready_o   = (state_q == ST_FILL) | ack_i;
    assign capture_o = en_i & ready_o;
    assign valid_o   = (state_q == ST_FULL);
    assign count_o   = count_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (state_q == ST_FILL) begin
            if (capture_o) begin
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(NUM_TAPS - 1)) begin
                    state_d = ST_FULL;
                end
            end
        end else if (ack_i) begin
            // An ack with a word present starts the next vector immediately.
            state_d = ST_FILL;
            count_d = en_i ? CNT_W'(1) : '0;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ST_FILL;
            count_q <= '0;
        end else if (clr_i) begin
            state_q <= ST_FILL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

`ifdef SIPO_IN_OVF_EN
    logic ovf_q, ovf_d;

    assign ovf_d      = ovf_q | (en_i & ~ready_o);
    assign overflow_o = ovf_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ovf_q <= 1'b0;
        end else if (clr_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`else
    assign overflow_o = 1'b0;
`endif

endmodule

// File: rtl/sipo_in.sv
// Serial-in/parallel-out collector: shifts NUM_TAPS words in, first word ends
// at the MSB slice. Optional sticky OVERFLOW flag via SIPO_IN_OVF_EN.
module sipo_in
    import npu_io_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_TAPS = 4,
    localparam int CNT_W   = clog2(NUM_TAPS + 1)
) (
    input  logic                      CLKEXT,
    input  logic                      CLR_PISO_OUT,
    input  logic                      CLR_SIPO,
    input  logic                      EN_SIPO_IN,
    input  logic [WIDTH-1:0]          DATA_IN,
    output logic                      READY,
    output logic [WIDTH*NUM_TAPS-1:0] DATA_OUT,
    output logic                      DATA_VALID,
    input  logic                      DATA_ACK,
    output logic [CNT_W-1:0]          COUNT,
    output logic                      OVERFLOW
);

    logic                                capture;
    logic [NUM_TAPS-1:0][WIDTH-1:0] slice_q, slice_d;

    sipo_in_ctrl #(
        .NUM_TAPS (NUM_TAPS),
        .CNT_W    (CNT_W)
    ) u_ctrl (
        .clk_i      (CLKEXT),
        .arst_i     (CLR_PISO_OUT),
        .clr_i      (CLR_SIPO),
        .en_i       (EN_SIPO_IN),
        .ack_i      (DATA_ACK),
        .ready_o    (READY),
        .capture_o  (capture),
        .valid_o    (DATA_VALID),
        .count_o    (COUNT),
        .overflow_o (OVERFLOW)
    );

    generate
        for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_slice
            if (gi == 0) begin : g_head
                assign slice_d[gi] = DATA_IN;
            end else begin : g_tail
                assign slice_d[gi] = slice_q[gi-1];
            end
        end
    endgenerate

    // Slices are not cleared on ack; stale data stays until overwritten.
    always_ff @(posedge CLKEXT or posedge CLR_PISO_OUT) begin
        if (CLR_PISO_OUT) begin
            slice_q <= '0;
        end else if (CLR_SIPO) begin
            slice_q <= '0;
        end else if (capture) begin
            slice_q <= slice_d;
        end
    end

    assign DATA_OUT = slice_q;

endmodule

// File: tb/tb_sipo_in.sv
// Self-checking bench for sipo_in (WIDTH=8, NUM_TAPS=4) using a behavioural
// model and a scoreboard of completed vectors.
module tb_sipo_in;

    logic        CLKEXT = 1'b0;
    logic        CLR_PISO_OUT;
    logic        CLR_SIPO;
    logic        EN_SIPO_IN;
    logic [7:0]  DATA_IN;
    logic        READY;
    logic [31:0] DATA_OUT;
    logic        DATA_VALID;
    logic        DATA_ACK;
    logic [2:0]  COUNT;
    logic        OVERFLOW;

    sipo_in #(.WIDTH(8), .NUM_TAPS(4)) dut (
        .CLKEXT       (CLKEXT),
        .CLR_PISO_OUT (CLR_PISO_OUT),
        .CLR_SIPO     (CLR_SIPO),
        .EN_SIPO_IN   (EN_SIPO_IN),
        .DATA_IN      (DATA_IN),
        .READY        (READY),
        .DATA_OUT     (DATA_OUT),
        .DATA_VALID   (DATA_VALID),
        .DATA_ACK     (DATA_ACK),
        .COUNT        (COUNT),
        .OVERFLOW     (OVERFLOW)
    );

    always #5 CLKEXT = ~CLKEXT;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb_q[$];
    logic [31:0] m_vec;
    int          m_count;
    logic        m_ovf;
    logic        seen_valid;
    logic        ovf_build;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_vec      = '0;
        m_count    = 0;
        m_ovf      = 1'b0;
        seen_valid = 1'b0;
    endtask

    // One clock: drive inputs, check READY, clock, update model, check outputs.
    task automatic cyc(input logic en, input logic [7:0] d, input logic ack, input logic clr);
        logic m_ready;
        EN_SIPO_IN = en;
        DATA_IN    = d;
        DATA_ACK   = ack;
        CLR_SIPO   = clr;
        m_ready    = (m_count < 4) || ack;
        #1;
        check("ready", {31'b0, READY}, {31'b0, m_ready});
        @(posedge CLKEXT);
        if (clr) begin
            model_reset();
        end else begin
            if (en && !m_ready && ovf_build) m_ovf = 1'b1;
            if (en && m_ready) begin
                m_vec   = {m_vec[23:0], d};
                m_count = (m_count == 4) ? 1 : m_count + 1;
                if (m_count == 4) sb_q.push_back(m_vec);
            end else if (m_count == 4 && ack) begin
                m_count = 0;
            end
        end
        #1;
        check("count", {29'b0, COUNT}, 32'(m_count));
        check("valid", {31'b0, DATA_VALID}, {31'b0, (m_count == 4)});
        check("overflow", {31'b0, OVERFLOW}, {31'b0, m_ovf});
        if (DATA_VALID && !seen_valid) begin
            seen_valid = 1'b1;
            if (sb_q.size() == 0) check("sb_unexpected_valid", 32'd1, 32'd0);
            else check("sb_vec", DATA_OUT, sb_q.pop_front());
        end else if (!DATA_VALID) begin
            seen_valid = 1'b0;
        end
        EN_SIPO_IN = 1'b0;
        DATA_ACK   = 1'b0;
        CLR_SIPO   = 1'b0;
    endtask

    initial begin
`ifdef SIPO_IN_OVF_EN
        ovf_build = 1'b1;
`else
        ovf_build = 1'b0;
`endif
        CLR_PISO_OUT = 1'b1;
        CLR_SIPO     = 1'b0;
        EN_SIPO_IN   = 1'b0;
        DATA_IN      = '0;
        DATA_ACK     = 1'b0;
        model_reset();
        #1;
        check("rst_data", DATA_OUT, 32'h0);
        check("rst_count", {29'b0, COUNT}, 32'h0);
        check("rst_valid", {31'b0, DATA_VALID}, 32'h0);
        check("rst_ovf", {31'b0, OVERFLOW}, 32'h0);
        #11;
        CLR_PISO_OUT = 1'b0;
        #1;
        check("rst_ready", {31'b0, READY}, 32'h1);
        @(posedge CLKEXT);
        #1;

        // Basic fill
        cyc(1, 8'h11, 0, 0);
        cyc(1, 8'h22, 0, 0);
        cyc(1, 8'h33, 0, 0);
        cyc(1, 8'h44, 0, 0);
        check("fill_data", DATA_OUT, 32'h11223344);
        check("fill_count", {29'b0, COUNT}, 32'd4);

        // Hold and drop
        cyc(1, 8'h99, 0, 0);
        check("drop_data", DATA_OUT, 32'h11223344);
        cyc(0, 8'h00, 0, 0);
        check("hold_data", DATA_OUT, 32'h11223344);

        // Back-to-back with ack + en together
        cyc(1, 8'hAA, 1, 0);
        cyc(1, 8'hBB, 0, 0);
        cyc(1, 8'hCC, 0, 0);
        cyc(1, 8'hDD, 0, 0);
        check("b2b_data", DATA_OUT, 32'hAABBCCDD);

        // Sticky overflow cleared by CLR_SIPO
        cyc(0, 8'h00, 0, 1);
        check("clr_data", DATA_OUT, 32'h0);

        // Gapped input
        cyc(1, 8'h01, 0, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(1, 8'h02, 0, 0);
        cyc(1, 8'h03, 0, 0);
        cyc(1, 8'h04, 0, 0);
        check("gap_data", DATA_OUT, 32'h01020304);
        cyc(0, 8'h00, 1, 0);

        // Async reset mid-fill, between edges
        cyc(1, 8'h5A, 0, 0);
        cyc(1, 8'hA5, 0, 0);
        #2;
        CLR_PISO_OUT = 1'b1;
        #1;
        check("arst_data", DATA_OUT, 32'h0);
        check("arst_count", {29'b0, COUNT}, 32'h0);
        CLR_PISO_OUT = 1'b0;
        model_reset();

        // CLR_SIPO together with EN discards the word
        cyc(1, 8'h77, 0, 0);
        cyc(1, 8'h66, 0, 1);
        check("sclr_data", DATA_OUT, 32'h0);

        // Round trip from a word-serial source, MSB word first
        for (int it = 0; it < 1000; it++) begin
            logic [31:0] vec;
            vec = $urandom;
            for (int k = 3; k >= 0; k--) begin
                if ($urandom_range(0, 3) == 0) cyc(0, 8'h00, 0, 0);
                cyc(1, vec[8*k +: 8], (m_count == 4), 0);
            end
            cyc(0, 8'h00, 0, 0);
            check("rt_data", DATA_OUT, vec);
        end
        cyc(0, 8'h00, 1, 0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sipo_in.md
Name: sipo_in

Overview:
Serial-in/parallel-out input collector. It is the receive-side counterpart of the NPU's word-serial output shifter. It accepts one WIDTH-bit word per enabled cycle and assembles NUM_TAPS words into one parallel vector. It then presents the vector to the downstream consumer with a valid/ack handshake. Word ordering is chosen so that a vector emitted by the output shifter is reproduced bit-exact.

Parameters:
WIDTH, 8, bits per serial word.
NUM_TAPS, 4, words per parallel vector. Legal range is NUM_TAPS >= 2.
CNT_W, derived clog2(NUM_TAPS+1), width of COUNT. This is a localparam, not overridable.

Ports:
CLKEXT  in  1  clock, rising edge.
CLR_PISO_OUT  in  1  asynchronous active-high reset.
CLR_SIPO  in  1  synchronous clear, active-high.
EN_SIPO_IN  in  1  DATA_IN holds a valid word this cycle.
DATA_IN  in  WIDTH  serial word.
READY  out  1  block accepts a word this cycle (combinational).
DATA_OUT  out  WIDTH*NUM_TAPS  assembled vector; slice i = DATA_OUT[WIDTH*i +: WIDTH].
DATA_VALID  out  1  DATA_OUT is complete and stable.
DATA_ACK  in  1  consumer takes DATA_OUT this cycle (meaningful only while DATA_VALID=1).
COUNT  out  CNT_W  words held in the current vector, 0..NUM_TAPS.
OVERFLOW  out  1  sticky error flag. Present only with SIPO_IN_OVF_EN; otherwise tied 0.

Behaviour:
- Reset: CLR_PISO_OUT=1 asynchronously forces the following. All slices 0. COUNT=0. State=FILL. DATA_VALID=0. OVERFLOW=0. READY=1 as soon as reset deasserts.
- Priority on each CLKEXT edge: CLR_PISO_OUT > CLR_SIPO > capture/ack.
- CLR_SIPO has the same effect as reset, applied at the clock edge. Any in-flight capture or ack in that cycle is discarded.
- States:
  - FILL: COUNT < NUM_TAPS.
  - FULL: COUNT = NUM_TAPS, DATA_VALID=1.
- READY = (state==FILL) | (state==FULL & DATA_ACK).
- Capture occurs on an edge where EN_SIPO_IN & READY:
  - slice 0 <= DATA_IN;
  - slice i <= slice i-1 for i = 1..NUM_TAPS-1;
  - so the first word of a vector ends in slice NUM_TAPS-1 (MSB end).
- FILL with capture: COUNT increments. When the captured word is the NUM_TAPS-th, move to FULL. DATA_VALID rises in the cycle after that edge (latency of 1 edge from the last word).
- FULL without DATA_ACK: DATA_OUT and COUNT are frozen.
- FULL with DATA_ACK and no EN: move to FILL, COUNT=0, DATA_VALID=0. Slices keep stale data (not cleared).
- FULL with DATA_ACK and EN in the same cycle: the word is captured as the first word of the next vector. COUNT=1, state FILL, DATA_VALID=0. Zero-bubble throughput.
- DATA_ACK in FILL is ignored.
- EN_SIPO_IN with READY=0 (FULL, no ack): the word is dropped. DATA_OUT is unchanged.
- DATA_OUT during FILL shows partial, shifting contents and is not qualified.

Optional Feature:
SIPO_IN_OVF_EN
- Defined: any cycle with EN_SIPO_IN & !READY sets OVERFLOW on the next edge. OVERFLOW stays set until CLR_SIPO or CLR_PISO_OUT.
- Undefined: dropped words leave no trace. OVERFLOW is driven constant 0; the port remains so instantiations are identical in both builds.

Decomposition:
- Shared package npu_io_pkg holds:
  - state encodings ST_FILL=1'b0 and ST_FULL=1'b1, shared with future I/O blocks;
  - a clog2 constant function used for CNT_W.
- One natural sub-module, sipo_in_ctrl, holds the FSM, COUNT, and the READY/DATA_VALID/OVERFLOW logic. The top level holds the shift-register datapath and takes the capture enable from sipo_in_ctrl.

Test Plan:
- Basic fill (WIDTH=8, NUM_TAPS=4): after reset, feed 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> DATA_VALID=1 the next cycle, DATA_OUT=0x11223344, COUNT=4, READY=0.
- Hold and drop: in FULL with no ack, pulse EN with 0x99 -> DATA_OUT stays 0x11223344. With SIPO_IN_OVF_EN, OVERFLOW=1 next cycle and stays 1 until CLR_SIPO.
- Back-to-back: in FULL, assert DATA_ACK together with EN and 0xAA, then 0xBB, 0xCC, 0xDD -> DATA_VALID drops for exactly 3 cycles, then returns with DATA_OUT=0xAABBCCDD. No word lost.
- Gapped input: feed 0x01, idle 2 cycles, then 0x02, 0x03, 0x04 -> COUNT steps 1,1,1,2,3,4 and DATA_OUT=0x01020304.
- Reset and clear mid-fill: after 2 words, assert CLR_PISO_OUT asynchronously between edges -> DATA_OUT=0 and COUNT=0 immediately. Repeat with CLR_SIPO asserted in the same cycle as EN -> word discarded, COUNT=0 after the edge.
- Round trip: the output shifter loaded with a random 32-bit vector, serialising into sipo_in -> after 4 words, DATA_OUT equals the loaded vector. Run 1000 random iterations.
